// File: rtl/mesm6_defines.sv
// rtl/mesm6_defines.sv - PIC register map, dispatcher states and OFF decoding
package mesm6_defines;

  localparam logic [14:0] PIC_OFF    = 15'o0;
  localparam logic [14:0] PIC_IECCLR = 15'o2;
  localparam logic [14:0] PIC_IECSET = 15'o3;
  localparam logic [14:0] PIC_IEC    = 15'o4;
  localparam logic [14:0] PIC_IFSCLR = 15'o5;
  localparam logic [14:0] PIC_IFSSET = 15'o6;
  localparam logic [14:0] PIC_IFS    = 15'o7;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    RD_OFF,
    WR_CLR,
    PRESENT
  } state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_IRQ
  } grant_t;

  // OFF encodes the source as 48 - bit; zero or anything above 48 means nothing valid is pending.
  function automatic logic off_valid(input logic [5:0] off);
    return (off >= 6'd1) && (off <= 6'd48);
  endfunction

  function automatic logic [5:0] off_to_bit(input logic [5:0] off);
    return 6'd48 - off;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mesm6_irq_dispatch.sv
// rtl/mesm6_irq_dispatch.sv - arbitrates CPU register accesses and PIC interrupt dispatch
module mesm6_irq_dispatch
  import mesm6_defines::*;
#(
  parameter int TMO_CYC  = 16,
  parameter int AUTO_CLR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [47:0] cpu_wdata,
  output logic [47:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        irq_en,
  output logic        irq_req,
  output logic [5:0]  irq_vec,
  input  logic        irq_ack,
  input  logic        pic_int,
  output logic [14:0] pic_addr,
  output logic        pic_read,
  output logic        pic_write,
  output logic [47:0] pic_wdata,
  input  logic [47:0] pic_rdata,
  input  logic        pic_done
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

  state_t        state, state_d;
  grant_t        last_grant, last_grant_d;
  logic          arm, arm_d;
  logic [CW-1:0] tmo_cnt, tmo_cnt_d;
  logic [7:0]    spur_cnt, spur_cnt_d;
  logic [14:0]   pic_addr_d;
  logic          pic_read_d, pic_write_d;
  logic [47:0]   pic_wdata_d, cpu_rdata_d;
  logic          cpu_done_d, irq_req_d;
  logic [5:0]    irq_vec_d, off_v;
  logic          cpu_pend, irq_pend, tmo_hit;

  // Next-state and next-output logic; an ack is honoured whenever a vector is
  // being presented, including while a CPU access is served out of PRESENT.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    arm_d        = arm;
    tmo_cnt_d    = tmo_cnt;
    spur_cnt_d   = spur_cnt;
    pic_addr_d   = pic_addr;
    pic_read_d   = pic_read;
    pic_write_d  = pic_write;
    pic_wdata_d  = pic_wdata;
    cpu_rdata_d  = cpu_rdata;
    cpu_done_d   = 1'b0;
    irq_req_d    = irq_req;
    irq_vec_d    = irq_vec;
    off_v        = pic_rdata[5:0];
    cpu_pend     = (cpu_read | cpu_write) & arm;
    irq_pend     = pic_int & irq_en & ~irq_req;
    tmo_hit      = (tmo_cnt == TMO_LAST);

    if (!cpu_read && !cpu_write) arm_d = 1'b1;
    if (irq_req && irq_ack) irq_req_d = 1'b0;

    unique case (state)
      IDLE, PRESENT: begin
        if (cpu_pend && (!irq_pend || last_grant == GRANT_IRQ)) begin
          state_d      = CPU_ACC;
          last_grant_d = GRANT_CPU;
          tmo_cnt_d    = '0;
          pic_addr_d   = cpu_addr;
          pic_wdata_d  = cpu_wdata;
          pic_write_d  = cpu_write;
          pic_read_d   = cpu_read & ~cpu_write;
        end else if (irq_pend) begin
          state_d      = RD_OFF;
          last_grant_d = GRANT_IRQ;
          tmo_cnt_d    = '0;
          pic_addr_d   = PIC_OFF;
          pic_read_d   = 1'b1;
          pic_write_d  = 1'b0;
        end else if (!irq_req_d) begin
          state_d = IDLE;
        end
      end
      CPU_ACC: begin
        tmo_cnt_d = tmo_cnt + 1'b1;
        if (pic_done || tmo_hit) begin
          pic_read_d  = 1'b0;
          pic_write_d = 1'b0;
          cpu_done_d  = 1'b1;
          arm_d       = 1'b0;
          state_d     = irq_req_d ? PRESENT : IDLE;
          if (!pic_done) begin
            cpu_rdata_d = '1;
            spur_cnt_d  = sat_inc8(spur_cnt);
          end else if (pic_read) begin
            cpu_rdata_d = pic_rdata;
          end
        end
      end
      RD_OFF: begin
        tmo_cnt_d = tmo_cnt + 1'b1;
        if (pic_done) begin
          pic_read_d = 1'b0;
          if (off_valid(off_v)) begin
            irq_vec_d = off_to_bit(off_v);
            if (AUTO_CLR != 0) begin
              state_d     = WR_CLR;
              tmo_cnt_d   = '0;
              pic_addr_d  = PIC_IFSCLR;
              pic_wdata_d = 48'd1 << off_to_bit(off_v);
              pic_write_d = 1'b1;
            end else begin
              state_d   = PRESENT;
              irq_req_d = 1'b1;
            end
          end else begin
            spur_cnt_d = sat_inc8(spur_cnt);
            state_d    = IDLE;
          end
        end else if (tmo_hit) begin
          pic_read_d = 1'b0;
          spur_cnt_d = sat_inc8(spur_cnt);
          state_d    = IDLE;
        end
      end
      WR_CLR: begin
        tmo_cnt_d = tmo_cnt + 1'b1;
        if (pic_done) begin
          pic_write_d = 1'b0;
          irq_req_d   = 1'b1;
          state_d     = PRESENT;
        end else if (tmo_hit) begin
          pic_write_d = 1'b0;
          spur_cnt_d  = sat_inc8(spur_cnt);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_IRQ;
      arm        <= 1'b1;
      tmo_cnt    <= '0;
      spur_cnt   <= '0;
      pic_addr   <= '0;
      pic_read   <= 1'b0;
      pic_write  <= 1'b0;
      pic_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_done   <= 1'b0;
      irq_req    <= 1'b0;
      irq_vec    <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      arm        <= arm_d;
      tmo_cnt    <= tmo_cnt_d;
      spur_cnt   <= spur_cnt_d;
      pic_addr   <= pic_addr_d;
      pic_read   <= pic_read_d;
      pic_write  <= pic_write_d;
      pic_wdata  <= pic_wdata_d;
      cpu_rdata  <= cpu_rdata_d;
      cpu_done   <= cpu_done_d;
      irq_req    <= irq_req_d;
      irq_vec    <= irq_vec_d;
    end
  end

endmodule

// File: tb/tb_mesm6_irq_dispatch.sv
// tb/tb_mesm6_irq_dispatch.sv - directed bench for the interrupt dispatcher with a PIC model
module tb_mesm6_irq_dispatch;
  import mesm6_defines::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [47:0] cpu_wdata = '0;
  logic [47:0] cpu_rdata;
  logic        cpu_done;
  logic        irq_en = 1'b0, irq_ack = 1'b0;
  logic        irq_req;
  logic [5:0]  irq_vec;
  logic        pic_int;
  logic [14:0] pic_addr;
  logic        pic_read, pic_write;
  logic [47:0] pic_wdata;
  logic [47:0] pic_rdata = '0;
  logic        pic_done = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  logic [47:0] ifs = '0, iec = '0;
  logic [47:0] dev_irq = '0;
  logic        mute_rd = 1'b0, mute_wr = 1'b0, off_force = 1'b0;
  int          overlap = 0, done_cycles = 0;
  logic [14:0] log_addr[$];
  logic        log_wr[$];
  logic [47:0] log_data[$];

  logic [47:0] rd;
  int          cyc, d0;

  mesm6_irq_dispatch #(.TMO_CYC(TMO), .AUTO_CLR(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .irq_en(irq_en), .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .pic_int(pic_int), .pic_addr(pic_addr), .pic_read(pic_read), .pic_write(pic_write),
    .pic_wdata(pic_wdata), .pic_rdata(pic_rdata), .pic_done(pic_done)
  );

  always #5 clk = ~clk;

  assign pic_int = |(ifs & iec);

  function automatic logic [47:0] off_of(input logic [47:0] pend);
    for (int i = 0; i < 48; i++) if (pend[i]) return 48'(48 - i);
    return '0;
  endfunction

  function automatic logic [47:0] model_read(input logic [14:0] a);
    case (a)
      15'o0:   return off_force ? 48'd0 : off_of(ifs & iec);
      15'o4:   return iec;
      15'o7:   return ifs;
      default: return '0;
    endcase
  endfunction

  // PIC model: answers one cycle after a strobe is seen, on the falling edge
  always @(negedge clk) begin
    ifs = ifs | dev_irq;
    if (pic_read && pic_write) overlap++;
    if (cpu_done) done_cycles++;
    if (pic_done) begin
      pic_done = 1'b0;
    end else if (pic_read && !mute_rd) begin
      pic_rdata = model_read(pic_addr);
      pic_done = 1'b1;
      log_addr.push_back(pic_addr); log_wr.push_back(1'b0); log_data.push_back(pic_rdata);
    end else if (pic_write && !mute_wr) begin
      case (pic_addr)
        15'o2: iec = iec & ~pic_wdata;
        15'o3: iec = iec | pic_wdata;
        15'o4: iec = pic_wdata;
        15'o5: ifs = ifs & ~pic_wdata;
        15'o6: ifs = ifs | pic_wdata;
        15'o7: ifs = pic_wdata;
        default: ;
      endcase
      pic_done = 1'b1;
      log_addr.push_back(pic_addr); log_wr.push_back(1'b1); log_data.push_back(pic_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_data.delete();
  endtask

  task automatic chk_log(input string tag, input int i, input logic [14:0] a,
                         input logic w, input logic [47:0] d);
    if (i < log_addr.size()) begin
      chk({tag, "_addr"}, log_addr[i], a);
      chk({tag, "_wr"}, log_wr[i], w);
      chk({tag, "_data"}, log_data[i], d);
    end else begin
      chk({tag, "_present"}, log_addr.size(), i + 1);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [14:0] a, input logic [47:0] wd,
                            output logic [47:0] r, output int c);
    cpu_addr = a; cpu_wdata = wd; cpu_write = wr; cpu_read = !wr; c = 0;
    do begin tick(); c++; end while (!cpu_done && c < 200);
    chk("cpu_done_seen", cpu_done, 1'b1);
    r = cpu_rdata;
    cpu_read = 1'b0; cpu_write = 1'b0;
    tick();
  endtask

  task automatic wait_irq();
    int c = 0;
    while (!irq_req && c < 200) begin tick(); c++; end
    chk("irq_req_seen", irq_req, 1'b1);
  endtask

  task automatic ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("irq_req_dropped", irq_req, 1'b0);
  endtask

  task automatic pulse_dev(input int b);
    dev_irq = 48'd1 << b; tick(); dev_irq = '0; tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_pic_read", pic_read, 1'b0);
    chk("rst_pic_write", pic_write, 1'b0);
    chk("rst_pic_addr", pic_addr, 15'd0);
    chk("rst_pic_wdata", pic_wdata, 48'd0);
    chk("rst_cpu_done", cpu_done, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 48'd0);
    chk("rst_irq_req", irq_req, 1'b0);
    chk("rst_irq_vec", irq_vec, 6'd0);
    chk("rst_spur", dut.spur_cnt, 8'd0);
    chk("rst_state", dut.state, IDLE);
    reset = 1'b0;
    tick();

    // Scenario 1: CPU write IEC = 1<<9
    clear_log(); d0 = done_cycles;
    cpu_access(1'b1, 15'o4, 48'd1 << 9, rd, cyc);
    tick();
    chk("s1_latency", cyc, 2);
    chk("s1_done_cycles", done_cycles - d0, 1);
    chk("s1_n_acc", log_addr.size(), 1);
    chk_log("s1_acc", 0, 15'o4, 1'b1, 48'd1 << 9);
    chk("s1_irq_req", irq_req, 1'b0);
    cpu_access(1'b1, 15'o3, (48'd1 << 3) | (48'd1 << 5) | (48'd1 << 11) | (48'd1 << 20), rd, cyc);
    chk("s1_iec", iec, (48'd1 << 9) | (48'd1 << 3) | (48'd1 << 5) | (48'd1 << 11) | (48'd1 << 20));

    // Scenario 2: source 9 dispatched with auto-clear
    clear_log(); irq_en = 1'b1;
    pulse_dev(9);
    wait_irq();
    chk("s2_vec", irq_vec, 6'd9);
    chk_log("s2_off", 0, 15'o0, 1'b0, 48'd39);
    chk_log("s2_clr", 1, 15'o5, 1'b1, 48'd1 << 9);
    chk("s2_ifs", ifs, 48'd0);
    tick(); tick(); tick();
    chk("s2_hold_req", irq_req, 1'b1);
    chk("s2_hold_vec", irq_vec, 6'd9);
    ack();

    // Scenario 3a: tie after an IRQ grant -> CPU first
    irq_en = 1'b0; clear_log();
    pulse_dev(3);
    irq_en = 1'b1;
    cpu_access(1'b0, 15'o7, '0, rd, cyc);
    chk("s3a_cpu_latency", cyc, 2);
    chk("s3a_rdata", rd, 48'd1 << 3);
    wait_irq();
    chk("s3a_vec", irq_vec, 6'd3);
    chk_log("s3a_cpu", 0, 15'o7, 1'b0, 48'd1 << 3);
    chk_log("s3a_off", 1, 15'o0, 1'b0, 48'd45);
    chk_log("s3a_clr", 2, 15'o5, 1'b1, 48'd1 << 3);
    ack();

    // Scenario 3b: CPU granted last, so the next tie goes to the IRQ side
    cpu_access(1'b0, 15'o4, '0, rd, cyc);
    chk("s3b_iec_rd", rd, (48'd1 << 9) | (48'd1 << 3) | (48'd1 << 5) | (48'd1 << 11) | (48'd1 << 20));
    irq_en = 1'b0; clear_log();
    pulse_dev(11);
    irq_en = 1'b1;
    cpu_access(1'b0, 15'o7, '0, rd, cyc);
    chk("s3b_rdata", rd, 48'd0);
    chk_log("s3b_off", 0, 15'o0, 1'b0, 48'd37);
    chk_log("s3b_clr", 1, 15'o5, 1'b1, 48'd1 << 11);
    chk_log("s3b_cpu", 2, 15'o7, 1'b0, 48'd0);
    chk("s3b_req_kept", irq_req, 1'b1);
    chk("s3b_vec_kept", irq_vec, 6'd11);
    ack();

    // Scenario 4: PIC never answers a CPU read
    mute_rd = 1'b1;
    cpu_access(1'b0, 15'o7, '0, rd, cyc);
    mute_rd = 1'b0;
    chk("s4_latency", cyc, TMO + 1);
    chk("s4_rdata", rd, 48'o7777777777777777);
    chk("s4_spur", dut.spur_cnt, 8'd1);
    chk("s4_strobe_low", pic_read, 1'b0);

    // Scenario 5: OFF read returns 0
    off_force = 1'b1; irq_en = 1'b1;
    dev_irq = 48'd1 << 5; tick(); dev_irq = '0;
    cyc = 0;
    while (!pic_done && cyc < 50) begin tick(); cyc++; end
    chk("s5_done_seen", pic_done, 1'b1);
    irq_en = 1'b0;
    chk("s5_state_idle", dut.state, IDLE);
    chk("s5_no_req", irq_req, 1'b0);
    chk("s5_spur", dut.spur_cnt, 8'd2);
    off_force = 1'b0;
    tick();
    cpu_access(1'b1, 15'o5, 48'd1 << 5, rd, cyc);
    chk("s5_ifs_clr", ifs, 48'd0);

    // Scenario 6: reset asserted during WR_CLR
    mute_wr = 1'b1; irq_en = 1'b1;
    dev_irq = 48'd1 << 20; tick(); dev_irq = '0;
    cyc = 0;
    while (!pic_write && cyc < 50) begin tick(); cyc++; end
    chk("s6_in_wrclr", dut.state, WR_CLR);
    #2 reset = 1'b1;
    #1;
    chk("s6_pic_write", pic_write, 1'b0);
    chk("s6_pic_read", pic_read, 1'b0);
    chk("s6_pic_addr", pic_addr, 15'd0);
    chk("s6_pic_wdata", pic_wdata, 48'd0);
    chk("s6_cpu_rdata", cpu_rdata, 48'd0);
    chk("s6_irq_req", irq_req, 1'b0);
    chk("s6_irq_vec", irq_vec, 6'd0);
    chk("s6_spur", dut.spur_cnt, 8'd0);
    chk("s6_state", dut.state, IDLE);
    tick();
    irq_en = 1'b0; mute_wr = 1'b0; clear_log();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("s6_no_access", log_addr.size(), 0);
    chk("s6_idle_strobes", {pic_read, pic_write}, 2'b00);
    cpu_access(1'b0, 15'o7, '0, rd, cyc);
    chk("s6_new_rd", rd, 48'd1 << 20);
    chk("s6_one_access", log_addr.size(), 1);

    chk("strobe_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mesm6_irq_dispatch.md
MESM6_IRQ_DISPATCH -- requirements
Module: mesm6_irq_dispatch

Interface
REQ-001 Parameter TMO_CYC, default 16: number of cycles to wait for pic_done before a PIC access is aborted.
REQ-002 Parameter AUTO_CLR, default 1: when 1, the dispatcher clears the taken source in IFS through IFSCLR before presenting the vector.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high. Ports: clk in 1 (rising edge); reset in 1 (asynchronous, active-high).
REQ-004 CPU register port:
- cpu_addr in 15: PIC register address.
- cpu_read in 1: read strobe.
- cpu_write in 1: write strobe.
- cpu_wdata in 48: write data.
- cpu_rdata out 48: read data.
- cpu_done out 1: one-cycle completion pulse.
REQ-005 CPU interrupt port:
- irq_en in 1: global interrupt enable.
- irq_req out 1: vector valid.
- irq_vec out 6: source bit index, 0..47.
- irq_ack in 1: one-cycle accept pulse.
REQ-006 PIC port:
- pic_int in 1: the PIC interrupt output.
- pic_addr out 15: register address.
- pic_read out 1: read strobe.
- pic_write out 1: write strobe.
- pic_wdata out 48: write data.
- pic_rdata in 48: read data.
- pic_done in 1: access completion.

Function
REQ-007 States: IDLE, CPU_ACC, RD_OFF, WR_CLR, PRESENT.
REQ-008 All PIC-side outputs are registered, and strobes are driven in at most one of them at a time.
REQ-009 A CPU request is pending when (cpu_read | cpu_write) is high and the request is armed.
- Arm is set at reset.
- Arm is cleared on cpu_done.
- Arm is set again once both strobes have been low for at least one cycle.
REQ-010 An interrupt request is pending when pic_int & irq_en are high and irq_req is low.
REQ-011 IDLE arbitration:
- If only one requester is pending, it is granted.
- If both are pending, the requester not granted last time wins (alternating); last_grant resets to IRQ so that the CPU wins the first tie.
REQ-012 CPU grant, IDLE -> CPU_ACC:
- pic_addr, pic_wdata and the strobe are copied from the CPU port.
- If cpu_read and cpu_write are both high, the access is a write.
REQ-013 In CPU_ACC, on pic_done:
- Drop the strobe.
- Latch pic_rdata into cpu_rdata on a read; cpu_rdata is held otherwise.
- Pulse cpu_done for one cycle.
- Go to IDLE.
REQ-014 IRQ grant, IDLE -> RD_OFF: pic_addr = 'o0 (OFF), pic_read = 1.
REQ-015 In RD_OFF, on pic_done, with v = pic_rdata[5:0]:
- If 1 <= v <= 48, the source bit is b = 48 - v.
- Otherwise the event is spurious: irq_req is not raised, a spurious event is counted, and the FSM returns to IDLE.
REQ-016 Valid OFF with AUTO_CLR = 1: go to WR_CLR, with pic_addr = 'o5 (IFSCLR), pic_wdata = 1 << b, pic_write = 1. On pic_done, go to PRESENT.
REQ-017 Valid OFF with AUTO_CLR = 0: go directly to PRESENT.
REQ-018 PRESENT:
- irq_req = 1 and irq_vec = b, both held stable until irq_ack.
- On irq_ack, drop irq_req and go to IDLE.
- CPU register accesses are still served while in PRESENT (PRESENT acts as IDLE for CPU grants, and the vector is retained).
REQ-019 An irq_ack received outside PRESENT is ignored.
REQ-020 If irq_en falls during RD_OFF or WR_CLR, the sequence completes and PRESENT waits for the ack.
REQ-021 Timeout:
- A cycle counter runs in CPU_ACC, RD_OFF and WR_CLR and clears on each state entry.
- When it reaches TMO_CYC without pic_done, the strobe drops and the FSM aborts.
- In CPU_ACC, the abort pulses cpu_done with cpu_rdata = all ones.
- In RD_OFF or WR_CLR, the abort returns the FSM to IDLE with no vector.
REQ-022 Counters:
- spur_cnt is 8 bits, counts spurious events and aborts, and saturates at 255.
- spur_cnt is exposed only as an internal signal that the bench can probe.

Reset
REQ-023 Reset is asynchronous, takes effect immediately and is valid mid-access. Reset values:
- State = IDLE.
- pic_read = pic_write = 0; pic_addr = 0; pic_wdata = 0.
- cpu_done = 0; cpu_rdata = 0.
- irq_req = 0; irq_vec = 0.
- Timeout counter = 0; spur_cnt = 0.
- last_grant = IRQ; arm = 1.
REQ-024 An access that was in flight when reset asserted is not resumed after reset.

Structure
REQ-025 mesm6_defines.sv holds:
- The PIC register address constants (OFF 'o0, IECCLR 'o2, IECSET 'o3, IEC 'o4, IFSCLR 'o5, IFSSET 'o6, IFS 'o7).
- The dispatcher state enum.
- The OFF-to-bit conversion function.
REQ-026 The block is a single module with no sub-modules.

Verification
REQ-027 Scenario 1: CPU writes IEC = 1<<9 -> pic_write for one access, cpu_done for exactly one cycle, no irq_req.
REQ-028 Scenario 2: dev_irq bit 9, IEC bit 9, irq_en = 1 -> the PIC sees an OFF read returning 39, then an IFSCLR write of 1<<9; then irq_req = 1 with irq_vec = 9, and irq_req drops the cycle after irq_ack.
REQ-029 Scenario 3: a CPU read of IFS and pic_int rise in the same cycle -> the CPU access is served first, the OFF read follows; a second tie grants the IRQ sequence first.
REQ-030 Scenario 4: PIC model never asserts done on a CPU read -> cpu_done after 16 cycles with cpu_rdata = 'o7777777777777777, and spur_cnt = 1.
REQ-031 Scenario 5: OFF read returns 0 -> no irq_req, spur_cnt increments, and the FSM is in IDLE the next cycle.
REQ-032 Scenario 6: reset asserted during WR_CLR -> all outputs take their reset values immediately, and no access is issued after release until a new request arrives.
